// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset default and buffer entry type
// for the instruction fetch unit and its skid buffer.
package fetch_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 32;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam addr_t RESET_PC_DEFAULT = 12'h000;

  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } fetch_entry_t;

  // word address increment, wraps at the top of the space
  function automatic addr_t pc_inc(input addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: two-entry output buffer for fetched instructions.
// head is a register so consumer-facing outputs are glitch free.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t slot1;
  logic         do_pop;

  assign do_pop = pop && (count != 2'd0);

  // buffer occupancy and shifting; flush drops all entries
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 2'd0;
      head  <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case (1'b1)
        (push && do_pop): begin
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head  <= slot1;
            slot1 <= push_data;
          end
        end
        (push && !do_pop): begin
          if (count == 2'd0) begin
            head <= push_data;
          end else begin
            slot1 <= push_data;
          end
          count <= count + 2'd1;
        end
        (!push && do_pop): begin
          head  <= slot1;
          count <= count - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // the issue rule upstream must never overfill the buffer
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset)
    !(push && !do_pop && !flush && count == 2'd2)
  );

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with redirect and a
// two-entry valid/ready output buffer over a 1-cycle memory.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int                BUF_DEPTH = 2
)(
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  addr_t        pc;
  addr_t        tag;
  logic         inflight;
  logic [1:0]   count;
  logic [2:0]   occ;
  logic         redir;
  logic         xfer;
  logic         issue;
  logic         push;
  fetch_entry_t head;
  fetch_entry_t push_data;

  // redirect is meaningless while held in reset
  assign redir = redirect_valid && reset;
  assign xfer  = out_valid && out_ready;
  assign occ   = {1'b0, count} + {2'b00, inflight};

  // issue only when the returning word is sure to have a slot
  assign issue = (occ < 3'd2) || ((occ == 3'd2) && xfer);
  assign push  = inflight && !redir;

  // target goes out the same cycle the redirect arrives
  assign imem_addr = redir ? redirect_target : pc;

  assign push_data = '{instr: imem_rdata, pc: tag};

  // pc, pending-read flag and the address tag of that read
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc       <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
    end else if (redir) begin
      pc       <= pc_inc(redirect_target);
      tag      <= redirect_target;
      inflight <= 1'b1;
    end else if (issue) begin
      pc       <= pc_inc(pc);
      tag      <= pc;
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (xfer),
    .flush     (redir),
    .count     (count),
    .head      (head)
  );

  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  a_depth: assert property (@(posedge clk) BUF_DEPTH == 2);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed latency/ordering scenarios plus a random
// redirect/backpressure run against a stream-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [11:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [11:0] out_pc;

  logic [31:0] mem [4096];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic        hv    [64];
  logic [11:0] hpc   [64];
  logic [11:0] haddr [64];
  int          xc [$];
  logic [11:0] xp [$];
  logic [31:0] xi [$];

  fetch_unit #(.RESET_PC(12'h000), .BUF_DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic tick();
    @(negedge clk);
    if (cyc < 64) begin
      hv[cyc]    = out_valid;
      hpc[cyc]   = out_pc;
      haddr[cyc] = imem_addr;
    end
    if (reset && out_valid && out_ready) begin
      xc.push_back(cyc);
      xp.push_back(out_pc);
      xi.push_back(out_instr);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 12'h000;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    cyc = 0;
    xc.delete();
    xp.delete();
    xi.delete();
    for (int i = 0; i < 64; i++) begin
      hv[i] = 1'b0;
      hpc[i] = 12'h000;
      haddr[i] = 12'h000;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 12'h055;
    tick();
    tick();
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    tests_run++;
    if (out_pc !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_pc: got %h want 000", out_pc);
    end
    tests_run++;
    if (out_instr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_instr: got %h want 0", out_instr);
    end
    tests_run++;
    if (imem_addr !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_addr: got %h want 000", imem_addr);
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    run_to(8);
    tests_run++;
    if (hv[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_c1_valid: got %b want 0", hv[1]);
    end
    tests_run++;
    if (xp.size() != 6) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d want 6", xp.size());
    end
    for (int k = 0; k < 6 && k < xp.size(); k++) begin
      tests_run++;
      if (xc[k] !== k + 2 || xp[k] !== 12'(k) || xi[k] !== 32'(k * 4)) begin
        tests_failed++;
        $display("FAIL stream_%0d: got c%0d pc %h ins %h want c%0d pc %h ins %h",
                 k, xc[k], xp[k], xi[k], k + 2, 12'(k), 32'(k * 4));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    run_to(6);
    out_ready = 1'b1;
    run_to(12);
    tests_run++;
    if (hv[1] !== 1'b0 || hv[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_first_valid: got c1 %b c2 %b want 0 1", hv[1], hv[2]);
    end
    for (int c = 2; c < 6; c++) begin
      tests_run++;
      if (hv[c] !== 1'b1 || hpc[c] !== 12'h000 || haddr[c] !== 12'h002) begin
        tests_failed++;
        $display("FAIL bp_hold_c%0d: got v %b pc %h addr %h want 1 000 002",
                 c, hv[c], hpc[c], haddr[c]);
      end
    end
    tests_run++;
    if (xp.size() < 4) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d want >=4", xp.size());
    end
    for (int k = 0; k < 4 && k < xp.size(); k++) begin
      tests_run++;
      if (xc[k] !== k + 6 || xp[k] !== 12'(k) || xi[k] !== 32'(k * 4)) begin
        tests_failed++;
        $display("FAIL bp_order_%0d: got c%0d pc %h ins %h want c%0d pc %h",
                 k, xc[k], xp[k], xi[k], k + 6, 12'(k));
      end
    end
  endtask

  task automatic test_redirect();
    logic [11:0] ep;
    int ec;
    do_reset();
    out_ready = 1'b1;
    run_to(5);
    redirect_valid = 1'b1;
    redirect_target = 12'h100;
    tick();
    redirect_valid = 1'b0;
    run_to(10);
    tests_run++;
    if (haddr[5] !== 12'h100 || hv[6] !== 1'b0) begin
      tests_failed++;
      $display("FAIL redir_addr: got addr %h c6 valid %b want 100 0",
               haddr[5], hv[6]);
    end
    tests_run++;
    if (xp.size() != 7) begin
      tests_failed++;
      $display("FAIL redir_count: got %0d want 7", xp.size());
    end
    for (int k = 0; k < 7 && k < xp.size(); k++) begin
      ep = (k < 4) ? 12'(k) : 12'(12'h100 + k - 4);
      ec = (k < 4) ? k + 2 : k + 3;
      tests_run++;
      if (xc[k] !== ec || xp[k] !== ep || xi[k] !== {18'd0, ep, 2'b00}) begin
        tests_failed++;
        $display("FAIL redir_%0d: got c%0d pc %h ins %h want c%0d pc %h",
                 k, xc[k], xp[k], xi[k], ec, ep);
      end
    end
  endtask

  task automatic test_wrap();
    logic [11:0] ep [4];
    int n;
    ep[0] = 12'hFFE;
    ep[1] = 12'hFFF;
    ep[2] = 12'h000;
    ep[3] = 12'h001;
    do_reset();
    out_ready = 1'b1;
    run_to(3);
    redirect_valid = 1'b1;
    redirect_target = 12'hFFE;
    tick();
    redirect_valid = 1'b0;
    run_to(10);
    n = 0;
    for (int k = 0; k < xp.size(); k++) begin
      if (xc[k] > 3 && n < 4) begin
        tests_run++;
        if (xc[k] !== n + 5 || xp[k] !== ep[n] || xi[k] !== {18'd0, ep[n], 2'b00}) begin
          tests_failed++;
          $display("FAIL wrap_%0d: got c%0d pc %h ins %h want c%0d pc %h",
                   n, xc[k], xp[k], xi[k], n + 5, ep[n]);
        end
        n++;
      end
    end
    tests_run++;
    if (n != 4) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d want 4", n);
    end
  endtask

  task automatic test_double_redirect();
    int bad;
    do_reset();
    out_ready = 1'b1;
    run_to(4);
    redirect_valid = 1'b1;
    redirect_target = 12'h040;
    tick();
    redirect_target = 12'h080;
    tick();
    redirect_valid = 1'b0;
    run_to(10);
    bad = 0;
    for (int k = 0; k < xp.size(); k++) begin
      if (xp[k] == 12'h040) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL dbl_stale: got %0d entries pc 040 want 0", bad);
    end
    tests_run++;
    if (hv[5] !== 1'b0 || hv[6] !== 1'b0) begin
      tests_failed++;
      $display("FAIL dbl_gap: got c5 %b c6 %b want 0 0", hv[5], hv[6]);
    end
    tests_run++;
    if (hv[7] !== 1'b1 || hpc[7] !== 12'h080 || hpc[8] !== 12'h081) begin
      tests_failed++;
      $display("FAIL dbl_target: got c7 v %b pc %h c8 pc %h want 1 080 081",
               hv[7], hpc[7], hpc[8]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    run_to(4);
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 12'h300;
    out_ready = 1'b1;
    tick();
    reset = 1'b1;
    redirect_valid = 1'b0;
    run_to(10);
    tests_run++;
    if (hv[4] !== 1'b1 || hv[5] !== 1'b0 || haddr[5] !== 12'h000) begin
      tests_failed++;
      $display("FAIL rmid_flush: got c4 v %b c5 v %b addr %h want 1 0 000",
               hv[4], hv[5], haddr[5]);
    end
    tests_run++;
    if (xp.size() != 3) begin
      tests_failed++;
      $display("FAIL rmid_count: got %0d want 3", xp.size());
    end
    for (int k = 0; k < 3 && k < xp.size(); k++) begin
      tests_run++;
      if (xc[k] !== k + 7 || xp[k] !== 12'(k) || xi[k] !== 32'(k * 4)) begin
        tests_failed++;
        $display("FAIL rmid_%0d: got c%0d pc %h want c%0d pc %h",
                 k, xc[k], xp[k], k + 7, 12'(k));
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] exp_pc;
    logic [11:0] prev_pc;
    logic [31:0] prev_instr;
    logic        hold;
    int          gap;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    do_reset();
    exp_pc = 12'h000;
    hold = 1'b0;
    prev_pc = '0;
    prev_instr = '0;
    gap = 0;
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_target = 12'($urandom);
      @(negedge clk);
      if (hold) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_pc !== prev_pc || out_instr !== prev_instr) begin
          tests_failed++;
          $display("FAIL rnd_hold_%0d: got v %b pc %h ins %h want 1 %h %h",
                   i, out_valid, out_pc, out_instr, prev_pc, prev_instr);
        end
      end
      if (out_valid && out_ready) begin
        tests_run++;
        if (out_pc !== exp_pc || out_instr !== mem[exp_pc]) begin
          tests_failed++;
          $display("FAIL rnd_xfer_%0d: got pc %h ins %h want pc %h ins %h",
                   i, out_pc, out_instr, exp_pc, mem[exp_pc]);
        end
        exp_pc = exp_pc + 12'd1;
      end
      gap = out_valid ? 0 : gap + 1;
      if (i >= 2) begin
        tests_run++;
        if (gap > 1) begin
          tests_failed++;
          $display("FAIL rnd_gap_%0d: got %0d empty cycles want <=1", i, gap);
        end
      end
      hold = out_valid && !out_ready && !redirect_valid;
      prev_pc = out_pc;
      prev_instr = out_instr;
      if (redirect_valid) begin
        exp_pc = redirect_target;
        gap = 0;
      end
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i * 4);
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 12'h000;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_double_redirect();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
